// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parking_pkg
//  Description : Shared widths, FSM state type and the token rule used by both
//                the entry generator and the exit-side verifier.
//  Revision    : 1.0 - initial release
// ============================================================================
package parking_pkg;

  localparam int SPOT_W    = 3;
  localparam int NUM_SPOTS = 8;
  localparam int TOKEN_W   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    OPEN   = 2'd2,
    LOCKED = 2'd3
  } state_t;

  // Expected token: spot number XOR pattern rotated right by one.
  // Both ends of the car park call this so they can never disagree.
  function automatic logic [TOKEN_W-1:0] expected_token(
    input logic [SPOT_W-1:0] park,
    input logic [2:0]        pattern
  );
    return park ^ {pattern[0], pattern[2:1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/occupancy_map.sv
`default_nettype none
// ============================================================================
//  Module      : occupancy_map
//  Description : Per-spot occupied flags. A set and a clear may arrive in the
//                same cycle; the set wins so a freshly parked car is never lost.
//  Revision    : 1.0 - initial release
// ============================================================================
module occupancy_map
  import parking_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_set_valid,
  input  logic [SPOT_W-1:0]    i_set_idx,
  input  logic                 i_clr_valid,
  input  logic [SPOT_W-1:0]    i_clr_idx,
  output logic [NUM_SPOTS-1:0] o_occupancy
);

  logic [NUM_SPOTS-1:0] r_occ;
  logic [NUM_SPOTS-1:0] w_set_mask;
  logic [NUM_SPOTS-1:0] w_clr_mask;

  // Decode the set/clear requests into one-hot masks.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set_valid) w_set_mask[i_set_idx] = 1'b1;
    if (i_clr_valid) w_clr_mask[i_clr_idx] = 1'b1;
  end

  // Clear first, then OR in the set so a same-spot collision ends up occupied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else begin
      r_occ <= (r_occ & ~w_clr_mask) | w_set_mask;
    end
  end

  assign o_occupancy = r_occ;

endmodule
`default_nettype wire

// File: rtl/token_verification.sv
`default_nettype none
// ============================================================================
//  Module      : token_verification
//  Description : Exit-side token checker. Validates a departing car's token
//                against the shared token rule and the occupancy map, opens
//                the gate for a timed window on success and locks the exit for
//                a timed penalty after repeated failures.
//  Revision    : 1.0 - initial release
// ============================================================================
module token_verification
  import parking_pkg::*;
#(
  parameter int OPEN_CYCLES = 16,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 entry_valid,
  input  logic [SPOT_W-1:0]    entry_park_number,
  input  logic [2:0]           pattern,
  input  logic                 exit_valid,
  input  logic [SPOT_W-1:0]    exit_park_number,
  input  logic [TOKEN_W-1:0]   exit_token,
  output logic                 exit_ready,
  output logic                 gate_open,
  output logic                 grant,
  output logic                 deny,
  output logic                 locked,
  output logic [NUM_SPOTS-1:0] occupancy,
  output logic [2:0]           fail_count
);

  // The timer only ever holds (window length - 1), so log2 of the longer
  // window is enough bits.
  localparam int c_TIMER_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int c_TIMER_W   = (c_TIMER_MAX > 1) ? $clog2(c_TIMER_MAX) : 1;

  localparam logic [c_TIMER_W-1:0] c_OPEN_LOAD = c_TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [c_TIMER_W-1:0] c_LOCK_LOAD = c_TIMER_W'(LOCK_CYCLES - 1);
  localparam logic [2:0]           c_MAX_FAIL  = 3'(MAX_FAIL);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [SPOT_W-1:0]      r_park;
  logic [TOKEN_W-1:0]     r_token;
  logic [2:0]             r_fail_count;
  logic [2:0]             w_fail_inc;
  logic [c_TIMER_W-1:0]   r_timer;
  logic                   w_timer_done;
  logic                   w_match;
  logic                   w_grant;
  logic [NUM_SPOTS-1:0]   w_occupancy;

  // The check sees the registered map, so an entry landing in the CHECK
  // cycle does not influence that decision.
  assign w_match      = (r_token == expected_token(r_park, pattern)) && w_occupancy[r_park];
  assign w_fail_inc   = (r_fail_count >= c_MAX_FAIL) ? c_MAX_FAIL : (r_fail_count + 3'd1);
  assign w_timer_done = (r_timer == '0);
  assign w_grant      = (r_state == CHECK) && w_match;

  occupancy_map u_occupancy_map (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_set_valid (entry_valid),
    .i_set_idx   (entry_park_number),
    .i_clr_valid (w_grant),
    .i_clr_idx   (r_park),
    .o_occupancy (w_occupancy)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state selection.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (exit_valid) w_state_next = CHECK;
      CHECK: begin
        if (w_match)                       w_state_next = OPEN;
        else if (w_fail_inc == c_MAX_FAIL) w_state_next = LOCKED;
        else                               w_state_next = IDLE;
      end
      OPEN:    if (w_timer_done) w_state_next = IDLE;
      LOCKED:  if (w_timer_done) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Moore-style status outputs plus the CHECK-cycle verdict pulses.
  always_comb begin
    exit_ready = 1'b0;
    gate_open  = 1'b0;
    locked     = 1'b0;
    grant      = 1'b0;
    deny       = 1'b0;
    case (r_state)
      IDLE:    exit_ready = 1'b1;
      CHECK: begin
        grant = w_match;
        deny  = !w_match;
      end
      OPEN:    gate_open = 1'b1;
      LOCKED:  locked    = 1'b1;
      default: exit_ready = 1'b0;
    endcase
  end

  // Request capture, failure counter and window timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_park       <= '0;
      r_token      <= '0;
      r_fail_count <= '0;
      r_timer      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (exit_valid) begin
            r_park  <= exit_park_number;
            r_token <= exit_token;
          end
        end
        CHECK: begin
          if (w_match) begin
            r_fail_count <= '0;
            r_timer      <= c_OPEN_LOAD;
          end else begin
            r_fail_count <= w_fail_inc;
            if (w_fail_inc == c_MAX_FAIL) r_timer <= c_LOCK_LOAD;
          end
        end
        OPEN: begin
          if (!w_timer_done) r_timer <= r_timer - c_TIMER_W'(1);
        end
        LOCKED: begin
          if (w_timer_done) r_fail_count <= '0;
          else              r_timer      <= r_timer - c_TIMER_W'(1);
        end
        default: r_timer <= '0;
      endcase
    end
  end

  assign occupancy  = w_occupancy;
  assign fail_count = r_fail_count;

endmodule
`default_nettype wire
